// File: rtl/matmul_pkg.sv
// Shared definitions for the sequential matrix multiplier datapath:
// word width, result-buffer state encoding and the row-major address helper.
package matmul_pkg;

  localparam int unsigned WORD_W = 32;

  typedef enum logic [1:0] {
    S_CLEAR  = 2'd0,
    S_ACCEPT = 2'd1,
    S_ACK    = 2'd2,
    S_DRAIN  = 2'd3
  } buf_state_t;

  // Row-major linear address of element (row, col) in an m x m matrix.
  function automatic int unsigned lin_addr(input int unsigned row,
                                           input int unsigned col,
                                           input int unsigned m);
    return row * m + col;
  endfunction

endpackage

// File: rtl/result_mem.sv
// M*M x WORD_W result storage: one synchronous write port and two
// asynchronous read ports (accumulation feedback and drain).
module result_mem
  import matmul_pkg::*;
#(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = 4
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [WORD_W-1:0] wdata,
  input  logic [AW-1:0]     fb_addr,
  output logic [WORD_W-1:0] fb_data,
  input  logic [AW-1:0]     dr_addr,
  output logic [WORD_W-1:0] dr_data
);

  logic [WORD_W-1:0] mem [DEPTH];

  // Single write port; contents are zeroed by the owner's clear sweep.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign fb_data = mem[fb_addr];
  assign dr_data = mem[dr_addr];

endmodule

// File: rtl/result_matrix_buffer.sv
// Result matrix buffer: captures multiplier result strobes, feeds the stored
// element back as accumulation seed, and drains the matrix row-major.
// Optional feature: define RESULT_BUF_WCOUNT_EN to add the wr_count output.
module result_matrix_buffer
  import matmul_pkg::*;
#(
  parameter int unsigned M     = 4,
  parameter int unsigned M_LEN = $clog2(M)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic [31:0]       z_in,
  input  logic [M_LEN-1:0]  z_i,
  input  logic [M_LEN-1:0]  z_j,
  input  logic              z_stb,
  output logic              z_ack,
  output logic [31:0]       current_element,
  input  logic              mul_done,
  output logic [31:0]       out_data,
  output logic [M_LEN-1:0]  out_row,
  output logic [M_LEN-1:0]  out_col,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              busy
`ifdef RESULT_BUF_WCOUNT_EN
  ,
  output logic [15:0]       wr_count
`endif
);

  localparam int unsigned AW    = 2 * M_LEN;
  localparam int unsigned DEPTH = M * M;
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  buf_state_t        state;
  logic [AW-1:0]     ptr;
  logic              done_pend;
  logic              in_range;
  logic [AW-1:0]     fb_addr;
  logic [WORD_W-1:0] fb_data;
  logic              we;
  logic [AW-1:0]     waddr;
  logic [WORD_W-1:0] wdata;
  logic              accept_wr;

  assign in_range  = (32'(z_i) < M) && (32'(z_j) < M);
  assign fb_addr   = AW'(lin_addr(32'(z_i), 32'(z_j), M));
  assign accept_wr = (state == S_ACCEPT) && z_stb && !clear;

  // Write port arbitration: clear sweep owns the port while in S_CLEAR.
  always_comb begin
    we    = 1'b0;
    waddr = ptr;
    wdata = '0;
    if (state == S_CLEAR) begin
      we = 1'b1;
    end else if (accept_wr && in_range) begin
      we    = 1'b1;
      waddr = fb_addr;
      wdata = z_in;
    end
  end

  result_mem #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk     (clk),
    .we      (we),
    .waddr   (waddr),
    .wdata   (wdata),
    .fb_addr (fb_addr),
    .fb_data (fb_data),
    .dr_addr (ptr),
    .dr_data (out_data)
  );

  assign current_element = (state == S_CLEAR || !in_range) ? '0 : fb_data;
  assign out_row  = M_LEN'(32'(ptr) / M);
  assign out_col  = M_LEN'(32'(ptr) % M);
  assign out_last = out_valid && (ptr == LAST);

  // Control FSM with registered handshake/status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_CLEAR;
      ptr       <= '0;
      z_ack     <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b1;
      done_pend <= 1'b0;
    end else if (clear) begin
      state     <= S_CLEAR;
      ptr       <= '0;
      z_ack     <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b1;
      done_pend <= 1'b0;
    end else begin
      case (state)
        S_CLEAR: begin
          if (ptr == LAST) begin
            ptr   <= '0;
            state <= S_ACCEPT;
            busy  <= 1'b0;
          end else begin
            ptr <= ptr + 1'b1;
          end
        end
        S_ACCEPT: begin
          if (z_stb) begin
            z_ack     <= 1'b1;
            done_pend <= mul_done;
            state     <= S_ACK;
          end else if (mul_done) begin
            ptr       <= '0;
            out_valid <= 1'b1;
            busy      <= 1'b1;
            state     <= S_DRAIN;
          end
        end
        S_ACK: begin
          // A done arriving while the strobe is still held is kept too.
          if (!z_stb) begin
            z_ack <= 1'b0;
            if (done_pend || mul_done) begin
              done_pend <= 1'b0;
              ptr       <= '0;
              out_valid <= 1'b1;
              busy      <= 1'b1;
              state     <= S_DRAIN;
            end else begin
              state <= S_ACCEPT;
            end
          end else if (mul_done) begin
            done_pend <= 1'b1;
          end
        end
        S_DRAIN: begin
          if (out_ready) begin
            if (ptr == LAST) begin
              ptr       <= '0;
              out_valid <= 1'b0;
              busy      <= 1'b0;
              state     <= S_ACCEPT;
            end else begin
              ptr <= ptr + 1'b1;
            end
          end
        end
        default: state <= S_CLEAR;
      endcase
    end
  end

`ifdef RESULT_BUF_WCOUNT_EN
  // Saturating count of accepted strobes since the last clear/reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_count <= '0;
    end else if (clear) begin
      wr_count <= '0;
    end else if (accept_wr && wr_count != 16'hFFFF) begin
      wr_count <= wr_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_result_matrix_buffer.sv
// Directed self-checking bench for result_matrix_buffer (M=4).
module tb_result_matrix_buffer;

  localparam int M  = 4;
  localparam int ML = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          clear = 1'b0;
  logic [31:0]   z_in = '0;
  logic [ML-1:0] z_i = '0;
  logic [ML-1:0] z_j = '0;
  logic          z_stb = 1'b0;
  logic          z_ack;
  logic [31:0]   current_element;
  logic          mul_done = 1'b0;
  logic [31:0]   out_data;
  logic [ML-1:0] out_row;
  logic [ML-1:0] out_col;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic          out_last;
  logic          busy;
`ifdef RESULT_BUF_WCOUNT_EN
  logic [15:0]   wr_count;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  result_matrix_buffer #(.M(M), .M_LEN(ML)) dut (
    .clk             (clk),
    .rst             (rst),
    .clear           (clear),
    .z_in            (z_in),
    .z_i             (z_i),
    .z_j             (z_j),
    .z_stb           (z_stb),
    .z_ack           (z_ack),
    .current_element (current_element),
    .mul_done        (mul_done),
    .out_data        (out_data),
    .out_row         (out_row),
    .out_col         (out_col),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_last        (out_last),
    .busy            (busy)
`ifdef RESULT_BUF_WCOUNT_EN
    ,
    .wr_count        (wr_count)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_elem(input logic [ML-1:0] i, input logic [ML-1:0] j,
                            input logic [31:0] v);
    int n;
    z_i = i; z_j = j; z_in = v; z_stb = 1'b1;
    n = 0;
    do begin tick(); n++; end while (!z_ack && n < 40);
    check("wr_ack_rise", {31'b0, z_ack}, 32'd1);
    z_stb = 1'b0;
    n = 0;
    do begin tick(); n++; end while (z_ack && n < 40);
    check("wr_ack_fall", {31'b0, z_ack}, 32'd0);
  endtask

  task automatic pulse_done();
    mul_done = 1'b1;
    tick();
    mul_done = 1'b0;
  endtask

  task automatic wait_idle(input string tag, output int n);
    n = 0;
    while (busy && n < 200) begin tick(); n++; end
    check(tag, {31'b0, busy}, 32'd0);
  endtask

  initial begin
    int n, idx, k;
    int pat [4] = '{1, 0, 0, 1};
    logic ack_seen;

    // Reset values
    repeat (3) tick();
    check("rst_busy",  {31'b0, busy},      32'd1);
    check("rst_ack",   {31'b0, z_ack},     32'd0);
    check("rst_valid", {31'b0, out_valid}, 32'd0);
    check("rst_last",  {31'b0, out_last},  32'd0);
    check("rst_row",   {30'b0, out_row},   32'd0);

    // Clear sweep after reset release: 16 cycles busy, no ack
    rst = 1'b0;
    n = 0; ack_seen = 1'b0;
    while (busy && n < 200) begin tick(); n++; ack_seen |= z_ack; end
    check("clear_len", n, 32'd16);
    check("clear_ack", {31'b0, ack_seen}, 32'd0);
    z_i = 2'd2; z_j = 2'd3; #1;
    check("ce_23_zero", current_element, 32'h0);

    // Single strobe and overwrite at (1,2)
    z_i = 2'd1; z_j = 2'd2; z_in = 32'h3F800000; z_stb = 1'b1;
    tick();
    check("ack_next", {31'b0, z_ack}, 32'd1);
    check("ce_12_first", current_element, 32'h3F800000);
    z_stb = 1'b0;
    tick();
    check("ack_drop", {31'b0, z_ack}, 32'd0);
    write_elem(2'd1, 2'd2, 32'h40000000);
    check("ce_12_over", current_element, 32'h40000000);

    // Fill and full-rate drain
    for (int e = 0; e < 16; e++) write_elem(ML'(e / M), ML'(e % M), 32'h41000000 + e);
    out_ready = 1'b1;
    pulse_done();
    for (int b = 0; b < 16; b++) begin
      check("dr_valid", {31'b0, out_valid}, 32'd1);
      check("dr_data",  out_data, 32'h41000000 + b);
      check("dr_row",   {30'b0, out_row}, b / M);
      check("dr_col",   {30'b0, out_col}, b % M);
      check("dr_last",  {31'b0, out_last}, (b == 15) ? 32'd1 : 32'd0);
      tick();
    end
    check("dr_end_valid", {31'b0, out_valid}, 32'd0);
    check("dr_end_busy",  {31'b0, busy},      32'd0);

    // Drain with ready pattern 1,0,0,1
    out_ready = 1'b0;
    pulse_done();
    idx = 0; k = 0;
    while (idx < 16 && k < 200) begin
      out_ready = (pat[k % 4] != 0);
      check("st_data", out_data, 32'h41000000 + idx);
      check("st_row",  {30'b0, out_row}, idx / M);
      check("st_col",  {30'b0, out_col}, idx % M);
      tick();
      if (out_ready) idx++;
      k++;
    end
    check("st_count", idx, 32'd16);
    check("st_end_valid", {31'b0, out_valid}, 32'd0);

    // Clear during drain at beat 5
    out_ready = 1'b1;
    pulse_done();
    repeat (5) tick();
    check("cd_beat5", out_data, 32'h41000005);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("cd_valid", {31'b0, out_valid}, 32'd0);
    check("cd_busy",  {31'b0, busy},      32'd1);
    wait_idle("cd_idle", n);
    check("cd_len", n, 32'd16);
    for (int e = 0; e < 16; e++) begin
      z_i = ML'(e / M); z_j = ML'(e % M); #1;
      check("cd_zero", current_element, 32'h0);
    end

    // Strobe during drain is held off until the last handshake
    pulse_done();
    z_i = 2'd0; z_j = 2'd0; z_in = 32'hA5A5A5A5; z_stb = 1'b1;
    ack_seen = 1'b0;
    for (int b = 0; b < 16; b++) begin ack_seen |= z_ack; tick(); end
    check("sd_no_ack", {31'b0, ack_seen}, 32'd0);
    check("sd_valid",  {31'b0, out_valid}, 32'd0);
    check("sd_ack_pre", {31'b0, z_ack}, 32'd0);
    tick();
    check("sd_ack", {31'b0, z_ack}, 32'd1);
    check("sd_ce",  current_element, 32'hA5A5A5A5);
    z_stb = 1'b0;
    tick();
    check("sd_ack_fall", {31'b0, z_ack}, 32'd0);

    // Full run: 64 accumulation writes, done coincident with the last strobe
    clear = 1'b1;
    tick();
    clear = 1'b0;
    wait_idle("fr_idle", n);
`ifdef RESULT_BUF_WCOUNT_EN
    check("fr_wc0", {16'b0, wr_count}, 32'd0);
`endif
    for (int e = 0; e < 16; e++)
      for (int s = 0; s < 4; s++)
        if (!(e == 15 && s == 3))
          write_elem(ML'(e / M), ML'(e % M), 32'h100 * e + s);
    z_i = 2'd3; z_j = 2'd3; z_in = 32'h100 * 15 + 3; z_stb = 1'b1; mul_done = 1'b1;
    tick();
    mul_done = 1'b0;
    check("fr_ack", {31'b0, z_ack}, 32'd1);
`ifdef RESULT_BUF_WCOUNT_EN
    check("fr_wc64", {16'b0, wr_count}, 32'd64);
`endif
    z_stb = 1'b0;
    tick();
    check("fr_ack_fall", {31'b0, z_ack}, 32'd0);
    check("fr_pend_drain", {31'b0, out_valid}, 32'd1);
    check("fr_beat0", out_data, 32'h3);
    n = 0;
    while (out_valid && n < 100) begin
      if (out_last) check("fr_last_data", out_data, 32'hF03);
      tick(); n++;
    end
    check("fr_beats", n, 32'd16);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout obs=running exp=finished");
    $fatal(1);
  end

endmodule
